// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default
// geometry of the instruction store and the opcodes the loader relies on.
package loader_pkg;

   localparam int DEPTH_DFLT = 32;
   localparam int AW_DFLT    = 5;
   localparam int DW_DFLT    = 8;

   // Empty instruction store words decode as NOP; HALT is the usual program end.
   localparam logic [7:0] NOP_OP  = 8'h00;
   localparam logic [7:0] HALT_OP = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Byte-wise modular sum used by the optional checksum stage.
   function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] full_s;
      full_s = {1'b0, a} + {1'b0, b};
      return full_s[7:0];
   endfunction

endpackage

// File: rtl/prog_ram.sv
// Instruction store: DEPTH x DW words, one synchronous write port, one
// asynchronous read port. Reset clears every word to zero (NOP).
module prog_ram #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] wadr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] radr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_r [DEPTH];

   // Storage array: cleared on reset, otherwise written on a write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
      end else if (we) begin
         mem_r[wadr] <= wdata;
      end
   end

   // The read is combinational, so a same-cycle write to the read address
   // is only visible after the clock edge (old value is returned).
   assign rdata = mem_r[radr];

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a byte stream over valid/ready, writes it into the
// instruction store and then releases the CPU through cpu_run. The CPU fetch
// path reads the same store through adr/instr.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to append a checksum byte
// to every load; the load only completes when data+checksum sums to 0 mod 256.
import loader_pkg::*;

module program_loader #(
   parameter int DEPTH = DEPTH_DFLT,
   parameter int AW    = AW_DFLT,
   parameter int DW    = DW_DFLT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   load_len,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic [AW-1:0] adr,
   output logic [DW-1:0] instr,
   output logic          cpu_run,
   output logic          busy,
   output logic          load_err
);

   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1'b1);

   state_t        state_r;
   state_t        state_nx_s;
   logic [AW-1:0] wr_ptr_r;
   logic [AW:0]   cnt_r;
   logic          in_ready_r;
   logic          busy_r;
   logic          cpu_run_r;
   logic          load_err_r;

   logic          in_ready_nx_s;
   logic          busy_nx_s;
   logic          cpu_run_nx_s;

   logic          len_ok_s;
   logic          idle_like_s;
   logic          start_ok_s;
   logic          start_bad_s;
   logic          xfer_s;
   logic          we_s;
   logic          last_s;
   logic          chk_fail_s;
   logic [DW-1:0] ram_rdata_s;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]    sum_r;
   logic          chk_xfer_s;
   logic          sum_ok_s;
`endif

   // A start is only honoured when no load is running (IDLE or DONE).
   assign len_ok_s    = (load_len != {(AW+1){1'b0}}) && (load_len <= LEN_MAX);
   assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
   assign start_ok_s  = start && idle_like_s && len_ok_s;
   assign start_bad_s = start && idle_like_s && !len_ok_s;

   // in_ready_r is high exactly in the byte-accepting states.
   assign xfer_s = in_valid && in_ready_r;
   assign we_s   = xfer_s && (state_r == ST_LOAD);
   assign last_s = we_s && (cnt_r == CNT_ONE);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   assign chk_xfer_s = xfer_s && (state_r == ST_CHECK);
   assign sum_ok_s   = (add8(sum_r, 8'(in_data)) == 8'h00);
   assign chk_fail_s = chk_xfer_s && !sum_ok_s;
`else
   assign chk_fail_s = 1'b0;
`endif

   // State register plus pointer, counter, registered outputs and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         wr_ptr_r   <= {AW{1'b0}};
         cnt_r      <= {(AW+1){1'b0}};
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         cpu_run_r  <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         in_ready_r <= in_ready_nx_s;
         busy_r     <= busy_nx_s;
         cpu_run_r  <= cpu_run_nx_s;

         if (start_ok_s) begin
            wr_ptr_r <= {AW{1'b0}};
            cnt_r    <= load_len;
         end else if (we_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            cnt_r    <= cnt_r - CNT_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
            cnt_r    <= cnt_r;
         end

         if (start_ok_s) begin
            load_err_r <= 1'b0;
         end else if (start_bad_s || chk_fail_s) begin
            load_err_r <= 1'b1;
         end else begin
            load_err_r <= load_err_r;
         end
      end
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   // Running 8-bit sum of the data bytes of the current load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r <= 8'h00;
      end else if (start_ok_s) begin
         sum_r <= 8'h00;
      end else if (we_s) begin
         sum_r <= add8(sum_r, 8'(in_data));
      end else begin
         sum_r <= sum_r;
      end
   end
`endif

   // Next-state logic of the load sequencer.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_nx_s = ST_LOAD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (last_s) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_nx_s = ST_CHECK;
`else
               state_nx_s = ST_DONE;
`endif
            end else begin
               state_nx_s = ST_LOAD;
            end
         end
         ST_CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (chk_xfer_s) begin
               if (sum_ok_s) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end else begin
               state_nx_s = ST_CHECK;
            end
`else
            state_nx_s = ST_IDLE;
`endif
         end
         ST_DONE: begin
            if (start_ok_s) begin
               state_nx_s = ST_LOAD;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state, so the outputs are registered and
   // already valid in the first cycle of each state.
   always_comb begin
      in_ready_nx_s = 1'b0;
      busy_nx_s     = 1'b0;
      cpu_run_nx_s  = 1'b0;
      case (state_nx_s)
         ST_LOAD, ST_CHECK: begin
            in_ready_nx_s = 1'b1;
            busy_nx_s     = 1'b1;
         end
         ST_DONE: begin
            cpu_run_nx_s = 1'b1;
         end
         ST_IDLE: begin
            cpu_run_nx_s = 1'b0;
         end
         default: begin
            cpu_run_nx_s = 1'b0;
         end
      endcase
   end

   prog_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we_s),
      .wadr  (wr_ptr_r),
      .wdata (in_data),
      .radr  (adr),
      .rdata (ram_rdata_s)
   );

   // The CPU sees NOPs while the store is being rewritten.
   assign instr    = busy_r ? DW'(NOP_OP) : ram_rdata_s;
   assign in_ready = in_ready_r;
   assign busy     = busy_r;
   assign cpu_run  = cpu_run_r;
   assign load_err = load_err_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_program_loader;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] load_len;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [4:0] adr;
   logic [7:0] instr;
   logic       cpu_run;
   logic       busy;
   logic       load_err;

   int errors = 0;
   int checks = 0;

   program_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .load_len (load_len),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .adr      (adr),
      .instr    (instr),
      .cpu_run  (cpu_run),
      .busy     (busy),
      .load_err (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic [5:0] len;
      logic       v;
      logic [7:0] d;
      logic [4:0] a;
      logic       rdy;
      logic       bsy;
      logic       run;
      logic       err;
      logic [7:0] ins;
   } row_t;

   row_t tbl[$];

   function automatic void add(logic st, logic [5:0] len, logic v, logic [7:0] d, logic [4:0] a,
                               logic rdy, logic bsy, logic run, logic err, logic [7:0] ins);
      row_t r;
      r.st = st; r.len = len; r.v = v; r.d = d; r.a = a;
      r.rdy = rdy; r.bsy = bsy; r.run = run; r.err = err; r.ins = ins;
      tbl.push_back(r);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; load_len = 6'd0; in_valid = 1'b0; in_data = 8'h00; adr = 5'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   // ---------------- behavioural model (spec rules) ----------------
   logic [7:0] m_mem [32];
   int         m_rem;
   int         m_ptr;
   bit         m_chk;
   bit         m_done;
   bit         m_err;
   logic [7:0] m_sum;

   function automatic bit m_loading();
      return (m_rem > 0) || m_chk;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
      m_rem = 0; m_ptr = 0; m_chk = 0; m_done = 0; m_err = 0; m_sum = 8'h00;
   endtask

   task automatic model_edge(bit st, int len, bit v, logic [7:0] d);
      logic [7:0] t;
      if (m_loading()) begin
         if (v) begin
            if (m_rem > 0) begin
               m_mem[m_ptr] = d;
               m_ptr++;
               m_sum = m_sum + d;
               m_rem--;
               if (m_rem == 0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  m_chk = 1;
`else
                  m_done = 1;
`endif
               end
            end else begin
               m_chk = 0;
               t = m_sum + d;
               if (t == 8'h00) m_done = 1;
               else m_err = 1;
            end
         end
      end else if (st) begin
         if (len >= 1 && len <= 32) begin
            m_rem = len; m_ptr = 0; m_err = 0; m_done = 0; m_sum = 8'h00;
         end else begin
            m_err = 1;
         end
      end
   endtask

   logic [7:0] prog6 [6];
   int nbytes;

   initial begin
      prog6[0] = 8'h93; prog6[1] = 8'h16; prog6[2] = 8'h27;
      prog6[3] = 8'h32; prog6[4] = 8'h7A; prog6[5] = 8'hFF;

      rst_n = 1'b0;
      idle_inputs();
      #12;

      // Reset state visible while reset is asserted
      chk("reset_ready", in_ready, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_run", cpu_run, 1'b0);
      chk("reset_err", load_err, 1'b0);
      rst_n = 1'b1;
      step();

      // Test 1: whole store reads as NOP after reset
      for (int i = 0; i < 32; i++) begin
         adr = 5'(i);
         #1;
         chk($sformatf("reset_mem[%0d]", i), instr, 8'h00);
      end

      // Directed table: load of 6 bytes, then load_len boundaries
      add(1, 6'd6, 0, 8'h00, 5'd0, 1, 1, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++) add(0, 6'd0, 1, prog6[i], 5'd0, 1, 1, 0, 0, 8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      add(0, 6'd0, 1, 8'hFF, 5'd0, 1, 1, 0, 0, 8'h00);
      add(0, 6'd0, 1, 8'h85, 5'd3, 0, 0, 1, 0, 8'h32);
`else
      add(0, 6'd0, 1, 8'hFF, 5'd3, 0, 0, 1, 0, 8'h32);
`endif
      add(0, 6'd0, 0, 8'h00, 5'd6, 0, 0, 1, 0, 8'h00);
      add(0, 6'd0, 0, 8'h00, 5'd0, 0, 0, 1, 0, 8'h93);
      add(0, 6'd0, 1, 8'h55, 5'd5, 0, 0, 1, 0, 8'hFF);
      add(1, 6'd0, 0, 8'h00, 5'd1, 0, 0, 1, 1, 8'h16);
      add(1, 6'd33, 0, 8'h00, 5'd2, 0, 0, 1, 1, 8'h27);
      add(1, 6'd1, 0, 8'h00, 5'd0, 1, 1, 0, 0, 8'h00);
      add(1, 6'd0, 1, 8'hA5, 5'd0, 0, 0, 0, 0, 8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      tbl[tbl.size()-1].rdy = 1; tbl[tbl.size()-1].bsy = 1;
      add(0, 6'd0, 1, 8'h5B, 5'd0, 0, 0, 1, 0, 8'hA5);
`else
      tbl[tbl.size()-1].run = 1; tbl[tbl.size()-1].ins = 8'hA5;
`endif
      add(0, 6'd0, 0, 8'h00, 5'd1, 0, 0, 1, 0, 8'h16);

      foreach (tbl[k]) begin
         start = tbl[k].st; load_len = tbl[k].len; in_valid = tbl[k].v;
         in_data = tbl[k].d; adr = tbl[k].a;
         step();
         chk($sformatf("tbl%0d_ready", k), in_ready, tbl[k].rdy);
         chk($sformatf("tbl%0d_busy", k), busy, tbl[k].bsy);
         chk($sformatf("tbl%0d_run", k), cpu_run, tbl[k].run);
         chk($sformatf("tbl%0d_err", k), load_err, tbl[k].err);
         chk($sformatf("tbl%0d_instr", k), instr, tbl[k].ins);
      end

      // Test 3: gapped stream (valid every other cycle)
      do_reset();
      start = 1'b1; load_len = 6'd6;
      step();
      start = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      nbytes = 7;
`else
      nbytes = 6;
`endif
      for (int k = 0; k < nbytes; k++) begin
         in_valid = 1'b0;
         step();
         chk("gap_ready_idle", in_ready, 1'b1);
         chk("gap_run_early", cpu_run, 1'b0);
         in_valid = 1'b1;
         in_data = (k < 6) ? prog6[k] : 8'h85;
         step();
         if (k == nbytes - 1) begin
            chk("gap_run_final", cpu_run, 1'b1);
            chk("gap_ready_final", in_ready, 1'b0);
         end else begin
            chk("gap_run_mid", cpu_run, 1'b0);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         adr = 5'(i);
         #1;
         chk($sformatf("gap_mem[%0d]", i), instr, (i < 6) ? prog6[i] : 8'h00);
      end

      // Test 5: reset in the middle of a load
      do_reset();
      start = 1'b1; load_len = 6'd6;
      step();
      start = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data = prog6[k];
         step();
      end
      in_valid = 1'b0; adr = 5'd0;
      chk("midrst_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", in_ready, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_run", cpu_run, 1'b0);
      chk("midrst_err", load_err, 1'b0);
      chk("midrst_instr0", instr, 8'h00);
      step();
      rst_n = 1'b1;
      step();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Test 6: checksum pass then fail
      start = 1'b1; load_len = 6'd2;
      step();
      start = 1'b0; in_valid = 1'b1;
      in_data = 8'h01; step();
      in_data = 8'h02; step();
      in_data = 8'hFD; step();
      in_valid = 1'b0;
      chk("cks_pass_run", cpu_run, 1'b1);
      chk("cks_pass_err", load_err, 1'b0);
      start = 1'b1; load_len = 6'd2;
      step();
      start = 1'b0; in_valid = 1'b1;
      in_data = 8'h01; step();
      in_data = 8'h02; step();
      in_data = 8'h00; step();
      in_valid = 1'b0; adr = 5'd1;
      #1;
      chk("cks_fail_err", load_err, 1'b1);
      chk("cks_fail_run", cpu_run, 1'b0);
      chk("cks_fail_ready", in_ready, 1'b0);
      chk("cks_fail_busy", busy, 1'b0);
      chk("cks_fail_ram", instr, 8'h02);
      start = 1'b1; load_len = 6'd1;
      step();
      start = 1'b0;
      chk("cks_fail_restart", in_ready, 1'b1);
      do_reset();
`endif

      // Randomized run against the model
      do_reset();
      model_reset();
      for (int n = 0; n < 4000; n++) begin
         bit         r_st;
         int         r_len;
         bit         r_v;
         logic [7:0] r_d;
         bit         exp_busy;
         r_st  = ($urandom % 12) == 0;
         r_len = $urandom_range(0, 34);
         r_v   = ($urandom % 3) != 0;
         r_d   = 8'($urandom);
         start = r_st; load_len = 6'(r_len); in_valid = r_v; in_data = r_d;
         adr   = 5'($urandom);
         model_edge(r_st, r_len, r_v, r_d);
         step();
         exp_busy = m_loading();
         chk("rnd_ready", in_ready, exp_busy);
         chk("rnd_busy", busy, exp_busy);
         chk("rnd_run", cpu_run, m_done && !exp_busy);
         chk("rnd_err", load_err, m_err);
         chk("rnd_instr", instr, exp_busy ? 8'h00 : m_mem[adr]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
